uart_rx_capture: RTL

- 8N1 UART receiver that consumes the SoC's serial transmit line (rocketTop uart_TX) and delivers received bytes on a valid/ready stream, buffered in a small FIFO.
- Used in the FPGA top as the console capture path. In simulation it sits next to the SoC as the byte-level console sink, feeding the console logger and host bridge.
- Single clock domain (100 MHz system clock). The serial input is asynchronous and is synchronised internally.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_capture.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART receive path
//
// Contents:
//   UART_DATA_BITS            data bits per frame (8N1)
//   UART_DEFAULT_CLKS_PER_BIT 100 MHz / 115200 baud
//   rx_state_t                receiver FSM states

package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through byte FIFO
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high, empties the FIFO
//   push       write push_data (accepted when not full, or when full with a pop)
//   push_data  byte to store
//   pop        remove the head entry (ignored when empty)
//   pop_data   head entry, reads 0 while empty
//   full       all FIFO_DEPTH entries occupied
//   empty      no entries

module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr addresses, so the write lands behind the new head.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - 8N1 UART receiver feeding a valid/ready byte stream through a FIFO
//
// Optional feature macro: UART_RX_CAPTURE_STATS_EN (byte and error counters).
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high
//   rx          asynchronous serial input, idles high
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data
//   out_data    head byte of the FIFO
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   overflow    sticky: a byte was dropped because the FIFO was full
//   clear_ovf   clears overflow (a same-cycle new overflow wins)
//   byte_count  accepted bytes, saturating (0 unless stats enabled)
//   err_count   framing errors plus dropped bytes, saturating (0 unless stats enabled)

module uart_rx_capture import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        frame_err,
  output logic        overflow,
  input  logic        clear_ovf,
  output logic [15:0] byte_count,
  output logic [15:0] err_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_BITS - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Two-flop synchroniser; reset to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_RELOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= BIT_RELOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= BIT_RELOAD;
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          // Hold off during a break so a low line cannot start a new frame.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push on the stop-sample edge itself so the byte is visible one cycle later.
  assign push      = (state == STOP) && (cnt == '0) && rx_s;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef UART_RX_CAPTURE_STATS_EN
  logic [15:0] byte_cnt_q;
  logic [15:0] err_cnt_q;
  logic        push_accepted;

  assign push_accepted = push && !drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push_accepted && (byte_cnt_q != 16'hFFFF)) byte_cnt_q <= byte_cnt_q + 16'd1;
      if ((frame_err || drop) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign byte_count = byte_cnt_q;
  assign err_count  = err_cnt_q;
`else
  assign byte_count = '0;
  assign err_count  = '0;
`endif

endmodule
